// File: rtl/shift_pkg.sv
// shift_pkg: definitions shared by the seq_shifter slice.
//   - MODE_* : operation encodings carried on in_mode (5..7 are illegal)
//   - state_t: engine FSM states, also exported on the dbg_state port
//   - mode_legal(): true for the five defined operations
package shift_pkg;

  localparam logic [2:0] MODE_SLL = 3'd0;
  localparam logic [2:0] MODE_SRL = 3'd1;
  localparam logic [2:0] MODE_SRA = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic mode_legal(input logic [2:0] mode);
    return (mode <= MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// shift_step: one combinational shift/rotate step.
// Ports:
//   value  in  WIDTH  working value
//   k      in  K_W    bits to move this step (0..WIDTH)
//   mode   in  3      MODE_* encoding; anything else passes value through
//   result out WIDTH  shifted value
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K_W   = 1
) (
  input  logic [WIDTH-1:0] value,
  input  logic [K_W-1:0]   k,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] result
);

  // Complement amount for rotates. When k is 0 this equals WIDTH, and a
  // shift by the full width yields 0, so the OR leaves value unchanged.
  logic [31:0] k_comp;

  always_comb begin
    k_comp = 32'(WIDTH) - 32'(k);
    result = value;
    case (mode)
      MODE_SLL: result = value << k;
      MODE_SRL: result = value >> k;
      MODE_SRA: result = $unsigned($signed(value) >>> k);
      MODE_ROL: result = (value << k) | (value >> k_comp);
      MODE_ROR: result = (value >> k) | (value << k_comp);
      default:  result = value;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift/rotate engine, one transaction at a time.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    request handshake
//   in_data/amt/mode     operand, shift amount, operation (MODE_*)
//   out_valid/out_ready  result handshake
//   out_data, out_err    result and illegal-mode flag (qualified by out_valid)
//   busy                 high while a transaction is in SHIFT or DONE
//   dbg_state            current FSM state
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. The producer holds valid and its payload until that edge;
// out_valid and the result stay stable until the consumer takes them.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int          K_W    = $clog2(STEP + 1);
  localparam logic [31:0] STEP_U = 32'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;

  logic             accept;
  logic             in_legal;
  logic [31:0]      rem_ext;
  logic [31:0]      k_ext;
  logic [K_W-1:0]   k;
  logic             last_step;
  logic [WIDTH-1:0] stepped;

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign in_legal = mode_legal(in_mode);

  // k = min(STEP, rem); the final step is the one where rem fits in STEP.
  assign rem_ext   = 32'(rem_q);
  assign k_ext     = (rem_ext > STEP_U) ? STEP_U : rem_ext;
  assign k         = K_W'(k_ext);
  assign last_step = (rem_ext <= STEP_U);

  shift_step #(
    .WIDTH (WIDTH),
    .K_W   (K_W)
  ) u_step (
    .value  (work_q),
    .k      (k),
    .mode   (mode_q),
    .result (stepped)
  );

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d = in_data;
          rem_d  = in_amt;
          mode_d = in_mode;
          // Nothing to shift (or nothing legal to do): result is the operand.
          if (!in_legal || (in_amt == '0)) begin
            out_data_d = in_data;
            out_err_d  = !in_legal;
            state_d    = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = stepped;
        rem_d  = rem_q - AMT_W'(k_ext);
        if (last_step) begin
          out_data_d = stepped;
          out_err_d  = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      rem_q      <= '0;
      mode_q     <= MODE_SLL;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: two instances (STEP=1 and STEP=3) fed the same
// requests, each checked against its own expected queue.
module tb_seq_shifter;
  import shift_pkg::*;

  localparam int W  = 8;
  localparam int AW = 4;
  // Queue entry: {accept edge[15:0], latency[7:0], err, data[W-1:0]}
  localparam int QW = 16 + 8 + 1 + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [W-1:0]  in_data  = '0;
  logic [AW-1:0] in_amt   = '0;
  logic [2:0]    in_mode  = '0;
  logic          out_ready = 1'b1;

  logic          in_valid1 = 1'b0, in_ready1, out_valid1, out_err1, busy1;
  logic [W-1:0]  out_data1;
  state_t        st1;
  logic          in_valid3 = 1'b0, in_ready3, out_valid3, out_err3, busy3;
  logic [W-1:0]  out_data3;
  state_t        st3;

  seq_shifter #(.WIDTH(W), .AMT_W(AW), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_err(out_err1),
    .busy(busy1), .dbg_state(st1)
  );

  seq_shifter #(.WIDTH(W), .AMT_W(AW), .STEP(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid3), .out_ready(out_ready),
    .out_data(out_data3), .out_err(out_err3),
    .busy(busy3), .dbg_state(st3)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [QW-1:0] exp_q1[$];
  logic [QW-1:0] exp_q3[$];
  bit bp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bit-at-a-time reference model.
  function automatic logic [W-1:0] model(input logic [2:0] mode, input logic [AW-1:0] amt,
                                         input logic [W-1:0] data);
    logic [W-1:0] r;
    r = data;
    if (mode > 3'd4) return data;
    for (int i = 0; i < int'(amt); i++) begin
      case (mode)
        3'd0:    r = {r[W-2:0], 1'b0};
        3'd1:    r = {1'b0, r[W-1:1]};
        3'd2:    r = {r[W-1], r[W-1:1]};
        3'd3:    r = {r[W-2:0], r[W-1]};
        default: r = {r[0], r[W-1:1]};
      endcase
    end
    return r;
  endfunction

  // Edges from the accept edge to the edge that enters DONE (out_valid is
  // decoded from DONE). Zero-amount and illegal requests enter DONE on the
  // accept edge itself, so out_valid is high in the very next cycle.
  function automatic int exp_lat(input logic [2:0] mode, input logic [AW-1:0] amt, input int step);
    if (mode > 3'd4 || amt == '0) return 0;
    return (int'(amt) + step - 1) / step;
  endfunction

  // ---------------- monitors ----------------
  bit           seen1 = 0, seen3 = 0;
  int           first1 = 0, first3 = 0;
  logic [W-1:0] held1 = '0, held3 = '0;

  always @(negedge clk) begin
    logic [QW-1:0] e;
    if (rst) seen1 = 0;
    else if (out_valid1) begin
      if (!seen1) begin seen1 = 1; first1 = cyc; held1 = out_data1; end
      else check("hold_data1", 32'(out_data1), 32'(held1));
      if (out_ready) begin
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out1 actual=%0h required=none", out_data1);
        end else begin
          e = exp_q1.pop_front();
          check("data1", 32'(out_data1), 32'(e[W-1:0]));
          check("err1", 32'(out_err1), 32'(e[W]));
          check("lat1", 32'(first1 - int'(e[QW-1:W+9])), 32'(e[W+8:W+1]));
        end
        seen1 = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [QW-1:0] e;
    if (rst) seen3 = 0;
    else if (out_valid3) begin
      if (!seen3) begin seen3 = 1; first3 = cyc; held3 = out_data3; end
      else check("hold_data3", 32'(out_data3), 32'(held3));
      if (out_ready) begin
        if (exp_q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out3 actual=%0h required=none", out_data3);
        end else begin
          e = exp_q3.pop_front();
          check("data3", 32'(out_data3), 32'(e[W-1:0]));
          check("err3", 32'(out_err3), 32'(e[W]));
          check("lat3", 32'(first3 - int'(e[QW-1:W+9])), 32'(e[W+8:W+1]));
        end
        seen3 = 0;
      end
    end
  end

  // Random backpressure, changed just after the edge so monitors see it stable.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [2:0] mode, input logic [AW-1:0] amt, input logic [W-1:0] data,
                      input logic [W-1:0] exp_data, input bit exp_err, input bit expect_out);
    bit p1 = 1, p3 = 1;
    int guard = 0;
    while ((p1 || p3) && guard < 200) begin
      @(negedge clk);
      in_data = data; in_amt = amt; in_mode = mode;
      in_valid1 = p1; in_valid3 = p3;
      if (p1 && in_ready1) begin
        if (expect_out)
          exp_q1.push_back({16'(cyc + 1), 8'(exp_lat(mode, amt, 1)), exp_err, exp_data});
        p1 = 0;
      end
      if (p3 && in_ready3) begin
        if (expect_out)
          exp_q3.push_back({16'(cyc + 1), 8'(exp_lat(mode, amt, 3)), exp_err, exp_data});
        p3 = 0;
      end
      guard++;
    end
    if (p1 || p3) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=pending%0d%0d required=accepted", p1, p3);
    end
    @(negedge clk);
    in_valid1 = 0; in_valid3 = 0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q1.size() != 0 || exp_q3.size() != 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_q1", 32'(exp_q1.size()), 32'd0);
    check("drain_q3", 32'(exp_q3.size()), 32'd0);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [W-1:0]  data;
    logic [W-1:0]  exp_data;
    logic          exp_err;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{3'd0, 4'd2,  8'hB3, 8'hCC, 1'b0};
    tbl[1]  = '{3'd2, 4'd3,  8'h90, 8'hF2, 1'b0};
    tbl[2]  = '{3'd1, 4'd3,  8'h90, 8'h12, 1'b0};
    tbl[3]  = '{3'd4, 4'd12, 8'hA5, 8'h5A, 1'b0};
    tbl[4]  = '{3'd0, 4'd9,  8'hFF, 8'h00, 1'b0};
    tbl[5]  = '{3'd3, 4'd7,  8'h81, 8'hC0, 1'b0};
    tbl[6]  = '{3'd1, 4'd0,  8'h3C, 8'h3C, 1'b0};
    tbl[7]  = '{3'd7, 4'd5,  8'h5E, 8'h5E, 1'b1};
    tbl[8]  = '{3'd2, 4'd15, 8'h7F, 8'h00, 1'b0};
    tbl[9]  = '{3'd2, 4'd15, 8'h80, 8'hFF, 1'b0};
    tbl[10] = '{3'd3, 4'd8,  8'h96, 8'h96, 1'b0};
    tbl[11] = '{3'd5, 4'd0,  8'h00, 8'h00, 1'b1};
    tbl[12] = '{3'd1, 4'd7,  8'h80, 8'h01, 1'b0};
    tbl[13] = '{3'd3, 4'd3,  8'h0F, 8'h78, 1'b0};

    // Reset state, with in_valid held high to show it is ignored.
    rst = 1'b1;
    in_valid1 = 1'b1; in_valid3 = 1'b1;
    in_mode = 3'd0; in_amt = 4'd3; in_data = 8'hAA;
    repeat (3) @(negedge clk);
    check("rst_in_ready1", 32'(in_ready1), 32'd0);
    check("rst_out_valid1", 32'(out_valid1), 32'd0);
    check("rst_out_data1", 32'(out_data1), 32'd0);
    check("rst_out_err1", 32'(out_err1), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_state1", 32'(st1), 32'(IDLE));
    check("rst_state3", 32'(st3), 32'(IDLE));
    check("rst_in_ready3", 32'(in_ready3), 32'd0);
    in_valid1 = 1'b0; in_valid3 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready1", 32'(in_ready1), 32'd1);
    check("idle_busy1", 32'(busy1), 32'd0);

    // Table vectors.
    for (int i = 0; i < 14; i++)
      send(tbl[i].mode, tbl[i].amt, tbl[i].data, tbl[i].exp_data, tbl[i].exp_err, 1'b1);
    drain();

    // Backpressure: result held for 5 cycles in DONE.
    @(posedge clk); #1 out_ready = 1'b0;
    send(3'd0, 4'd2, 8'hB3, 8'hCC, 1'b0, 1'b1);
    begin
      int guard = 0;
      while (!out_valid1 && guard < 50) begin @(negedge clk); guard++; end
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_valid1", 32'(out_valid1), 32'd1);
      check("bp_data1", 32'(out_data1), 32'hCC);
      check("bp_in_ready1", 32'(in_ready1), 32'd0);
      check("bp_busy1", 32'(busy1), 32'd1);
      check("bp_valid3", 32'(out_valid3), 32'd1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);                       // handshake happens at the next edge
    @(negedge clk);
    check("post_hs_in_ready1", 32'(in_ready1), 32'd1);
    check("post_hs_valid1", 32'(out_valid1), 32'd0);
    check("post_hs_data1", 32'(out_data1), 32'hCC);
    drain();

    // Reset during SHIFT: transaction dropped, no output handshake.
    send(3'd4, 4'd12, 8'hA5, 8'h00, 1'b0, 1'b0);
    check("mid_state1", 32'(st1), 32'(SHIFT));
    check("mid_state3", 32'(st3), 32'(SHIFT));
    check("mid_busy1", 32'(busy1), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_state1", 32'(st1), 32'(IDLE));
    check("mrst_valid1", 32'(out_valid1), 32'd0);
    check("mrst_data1", 32'(out_data1), 32'd0);
    check("mrst_busy1", 32'(busy1), 32'd0);
    check("mrst_state3", 32'(st3), 32'(IDLE));
    check("mrst_data3", 32'(out_data3), 32'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("mrst_quiet_valid1", 32'(out_valid1), 32'd0);
    check("mrst_in_ready1", 32'(in_ready1), 32'd1);

    // Random traffic with random backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [2:0]    m;
      logic [AW-1:0] a;
      logic [W-1:0]  d;
      m = 3'($urandom_range(0, 7));
      a = AW'($urandom_range(0, 15));
      d = W'($urandom_range(0, 255));
      send(m, a, d, model(m, a, d), (m > 3'd4), 1'b1);
    end
    bp_en = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
